serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Parametrised, bit-serial two's-complement arithmetic unit that replaces the fixed 16-bit ripple arithmetic and complement logic in the datapath.
- Computes add, subtract, negate or pass one bit per clock, LSB first, using a single full_adder cell plus a carry flop.
- Uses a start/ready/done handshake, so the controller can issue operations to it like any other multicycle unit.
- Result and flags are held stable until the next accepted operation.

Parameters:
- WIDTH, 16: operand/result width in bits; legal values are 2 and above.
- CNT_W, $clog2(WIDTH): localparam, bit-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only while ready=1.
- op  input  2  operation code: 00 ADD (a+b), 01 SUB (a-b), 10 NEG (0-a), 11 PASS (a).
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge; ignored for NEG and PASS.
- ready  output  1  high in IDLE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- y  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow.

Behaviour:
- Reset: reset_n=0 forces, asynchronously and regardless of state (including mid-RUN):
  - state=IDLE
  - y=0, cout=0, ovf=0
  - done=0, busy=0, ready=1
  - counter=0 and all internal shift and carry registers cleared
  - The in-flight operation is discarded with no done pulse.
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on a rising edge with start=1.
  - RUN→DONE on the edge that processes bit WIDTH-1.
  - DONE→IDLE unconditionally after one cycle.
- Operand setup on the accepting edge:
  - Operand registers load X and Y, and the carry flop loads cin:
    - ADD: X=a, Y=b, cin=0
    - SUB: X=a, Y=~b, cin=1
    - NEG: X=0, Y=~a, cin=1
    - PASS: X=a, Y=0, cin=0
  - The counter is cleared.
- RUN cycle:
  - full_adder takes X[0], Y[0] and carry.
  - Sum shifts into the MSB of the result shift register; X and Y shift right; carry updates; the counter increments.
  - On bit WIDTH-1, the carry into the MSB is captured for the overflow calculation.
- Entering DONE: y is loaded from the result shift register, cout from the final carry, and ovf = carry_into_MSB XOR final carry.
- Outputs during RUN: y, cout and ovf keep their previous values and never show partial results.
- Latency and throughput:
  - done is high in the cycle after the WIDTH-th edge following the accepting edge (the 16th edge for WIDTH=16).
  - ready returns the cycle after done.
  - Back-to-back issue takes WIDTH+2 cycles per operation.
- Start handling: start while busy or done is ignored, with no queuing. Changes on a, b or op after acceptance have no effect.
- Arithmetic wraps modulo 2^WIDTH. NEG of the most negative value returns the same value with ovf=1. NEG of 0 gives y=0, cout=1.
- Flags for PASS: cout=0, ovf=0 always.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package alu_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_NEG, OP_PASS)
  - addsub_state_t enum (S_IDLE, S_RUN, S_DONE)
- One sub-module, the existing one-bit full_adder cell, is instantiated once as the bit-slice. There is no other hierarchy.

Test Plan (all scenarios at WIDTH=16):
- ADD, a=0x1234, b=0x0FF1, start for 1 cycle: y=0x2225, cout=0, ovf=0. done pulses exactly 16 edges after acceptance and lasts 1 cycle. y is unchanged before done.
- SUB, a=0x0005, b=0x0007: y=0xFFFE, cout=0, ovf=0. SUB, a=0x8000, b=0x0001: y=0x7FFF, cout=1, ovf=1.
- NEG of a=0x8000: y=0x8000, cout=0, ovf=1. NEG of 0x0001: y=0xFFFF, ovf=0. NEG of 0x0000: y=0x0000, cout=1.
- ADD, a=0x7FFF, b=0x0001: y=0x8000, cout=0, ovf=1. ADD, a=0xFFFF, b=0x0001: y=0x0000, cout=1, ovf=0. PASS, a=0xBEEF: y=0xBEEF, flags 0.
- Start an ADD, then hold start=1 with new operands throughout RUN and DONE: only the first result appears and only one done pulse occurs. The second op is accepted on the first ready=1 edge, giving a WIDTH+2 cycle spacing.
- Drive reset_n low for 1 cycle midway through RUN (bit 7): y, cout, ovf, busy and done drop to 0 and ready rises to 1 immediately (asynchronously), with no done pulse. A following SUB 0x0010-0x0001 gives y=0x000F.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the bit-serial arithmetic unit.
//   op_t           : operation code carried on the request bus
//   addsub_state_t : control FSM states of serial_addsub
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } addsub_state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
// Request/response bundle between a controller and serial_addsub.
//   start, op, a, b          : request side, driven by the master
//   ready, busy, done        : handshake status, driven by the unit
//   y, cout, ovf             : registered result and flags
// ---------------------------------------------------------------------------
interface serial_addsub_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  ready, busy, done, y, cout, ovf
    );

    modport slave (
        input  start, op, a, b,
        output ready, busy, done, y, cout, ovf
    );

endinterface

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell used as the bit-slice of serial_addsub.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's-complement add / subtract / negate / pass unit. One bit is
// processed per clock, LSB first, through a single full_adder and a carry
// flop. A result is presented WIDTH+1 cycles after the accepting edge and is
// held, with its flags, until the next operation completes.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : serial_addsub_if slave (start/op/a/b in, ready/busy/done and
//             y/cout/ovf out)
// ---------------------------------------------------------------------------
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    serial_addsub_if.slave  bus
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    addsub_state_t    r_state;
    addsub_state_t    w_nextState;

    // r_x doubles as the result shift register: each consumed X bit leaves
    // the LSB while the new sum bit enters the MSB.
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_yOut;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_xLoad;
    logic [WIDTH-1:0] w_yLoad;
    logic             w_cinLoad;
    logic             w_sum;
    logic             w_carry;
    logic             w_lastBit;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;

    full_adder u_bitSlice (
        .i_a    (r_x[0]),
        .i_b    (r_y[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    assign w_lastBit = (r_cnt == LAST_BIT);

    // Subtraction and negation are folded into addition: invert the second
    // operand and inject a carry-in of one.
    always_comb begin
        w_xLoad   = bus.a;
        w_yLoad   = bus.b;
        w_cinLoad = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_xLoad   = bus.a;
                w_yLoad   = bus.b;
                w_cinLoad = 1'b0;
            end
            OP_SUB: begin
                w_xLoad   = bus.a;
                w_yLoad   = ~bus.b;
                w_cinLoad = 1'b1;
            end
            OP_NEG: begin
                w_xLoad   = '0;
                w_yLoad   = ~bus.a;
                w_cinLoad = 1'b1;
            end
            OP_PASS: begin
                w_xLoad   = bus.a;
                w_yLoad   = '0;
                w_cinLoad = 1'b0;
            end
            default: begin
                w_xLoad   = bus.a;
                w_yLoad   = bus.b;
                w_cinLoad = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // On the last bit the carry flop still holds the carry into the MSB, so
    // overflow is formed directly against the MSB carry-out on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_yOut  <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x     <= w_xLoad;
                        r_y     <= w_yLoad;
                        r_carry <= w_cinLoad;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_x     <= {w_sum, r_x[WIDTH-1:1]};
                    r_y     <= {1'b0, r_y[WIDTH-1:1]};
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_lastBit) begin
                        r_yOut <= {w_sum, r_x[WIDTH-1:1]};
                        r_cout <= w_carry;
                        r_ovf  <= r_carry ^ w_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.y     = r_yOut;
    assign bus.cout  = r_cout;
    assign bus.ovf   = r_ovf;

endmodule
